// File: rtl/redun_mont_vdf_ctrl.sv
// Sequencer for one redundant Montgomery multiplier core.
// Computes x^(2^t) mod P as: to-Montgomery, t squarings, from-Montgomery.
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_dat, i_t, i_val/o_rdy request: x (normal form) and squaring count t
//   o_dat, o_val/i_rdy      result x^(2^t) mod P (normal form)
//   o_mul_a, o_mul_b        core operands, held from launch until result
//   o_mul_val               one-cycle launch pulse to the core
//   i_mul_dat, i_mul_val    core Montgomery product and its strobe
//   o_iter                  squarings completed in the current job
//   o_busy                  job in progress
//   o_err                   sticky core-timeout flag
`timescale 1ns/1ps

module redun_mont_vdf_ctrl #(
    parameter int DAT_BITS    = 1040,
    parameter int T_BITS      = 64,
    parameter int TIMEOUT_CYC = 4096,
    // R^2 mod P for the modulus of the attached core
    parameter logic [DAT_BITS-1:0] MONT_RECIP_SQ = DAT_BITS'(1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DAT_BITS-1:0] i_dat,
    input  logic [T_BITS-1:0]   i_t,
    input  logic                i_val,
    output logic                o_rdy,
    output logic [DAT_BITS-1:0] o_dat,
    output logic                o_val,
    input  logic                i_rdy,
    output logic [DAT_BITS-1:0] o_mul_a,
    output logic [DAT_BITS-1:0] o_mul_b,
    output logic                o_mul_val,
    input  logic [DAT_BITS-1:0] i_mul_dat,
    input  logic                i_mul_val,
    output logic [T_BITS-1:0]   o_iter,
    output logic                o_busy,
    output logic                o_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [DAT_BITS-1:0] ONE = DAT_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH_TO,
        S_TO_MONT,
        S_LAUNCH_SQ,
        S_SQUARE,
        S_LAUNCH_FROM,
        S_FROM_MONT,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [T_BITS-1:0]   t_q;
    logic [T_BITS-1:0]   iter_inc;
    logic [TMO_W-1:0]    tmo_q;
    logic                waiting;
    logic                tmo_hit;
    logic                last_sq;

    assign iter_inc = o_iter + T_BITS'(1);

    assign waiting = (state == S_TO_MONT) ||
                     (state == S_SQUARE)  ||
                     (state == S_FROM_MONT);

    // A result arriving on the final allowed cycle still wins over the timeout.
    assign tmo_hit = waiting && !i_mul_val && (tmo_q == TMO_LAST);

    // True when the product being captured is the last one before conversion out.
    assign last_sq = (state == S_TO_MONT) ? (t_q == '0) : (iter_inc == t_q);

    assign o_rdy     = (state == S_IDLE);
    assign o_busy    = (state != S_IDLE);
    assign o_val     = (state == S_DONE);
    assign o_mul_val = (state == S_LAUNCH_TO) ||
                       (state == S_LAUNCH_SQ) ||
                       (state == S_LAUNCH_FROM);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:        if (i_val) state_n = S_LAUNCH_TO;
            S_LAUNCH_TO:   state_n = S_TO_MONT;
            S_LAUNCH_SQ:   state_n = S_SQUARE;
            S_LAUNCH_FROM: state_n = S_FROM_MONT;
            S_TO_MONT,
            S_SQUARE: begin
                if (tmo_hit) begin
                    state_n = S_IDLE;
                end else if (i_mul_val) begin
                    state_n = last_sq ? S_LAUNCH_FROM : S_LAUNCH_SQ;
                end
            end
            S_FROM_MONT: begin
                if (tmo_hit) begin
                    state_n = S_IDLE;
                end else if (i_mul_val) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:        if (i_rdy) state_n = S_IDLE;
            default:       state_n = S_IDLE;
        endcase
    end

    // Datapath: o_mul_a doubles as the Montgomery accumulator, so the
    // operands for the next launch are loaded at the capture edge and stay
    // put until the matching result returns.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            t_q     <= '0;
            o_iter  <= '0;
            o_dat   <= '0;
            o_mul_a <= '0;
            o_mul_b <= '0;
            tmo_q   <= '0;
            o_err   <= 1'b0;
        end else begin
            if (o_mul_val) begin
                tmo_q <= '0;
            end else if (waiting) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (tmo_hit) begin
                o_err <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (i_val) begin
                        t_q     <= i_t;
                        o_iter  <= '0;
                        o_mul_a <= i_dat;
                        o_mul_b <= MONT_RECIP_SQ;
                    end
                end
                S_TO_MONT,
                S_SQUARE: begin
                    if (i_mul_val) begin
                        o_mul_a <= i_mul_dat;
                        o_mul_b <= last_sq ? ONE : i_mul_dat;
                        if (state == S_SQUARE) begin
                            o_iter <= iter_inc;
                        end
                    end
                end
                S_FROM_MONT: begin
                    if (i_mul_val) begin
                        o_dat <= i_mul_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_redun_mont_vdf_ctrl.sv
// Bench for redun_mont_vdf_ctrl: small prime modulus, behavioural core
// model with variable latency, and a plain modular-power reference.
`timescale 1ns/1ps

module tb_redun_mont_vdf_ctrl;

    localparam int DW  = 1040;
    localparam int TW  = 64;
    localparam int TMO = 4096;
    // Core modelled with R = 2 mod P: R^2 = 4, R^-1 = (P+1)/2.
    localparam longint unsigned P    = 64'd1000003;
    localparam longint unsigned RINV = 64'd500002;

    logic          clk;
    logic          i_rst;
    logic [DW-1:0] i_dat;
    logic [TW-1:0] i_t;
    logic          i_val;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic          o_val;
    logic          i_rdy;
    logic [DW-1:0] o_mul_a;
    logic [DW-1:0] o_mul_b;
    logic          o_mul_val;
    logic [DW-1:0] i_mul_dat;
    logic          i_mul_val;
    logic [TW-1:0] o_iter;
    logic          o_busy;
    logic          o_err;

    redun_mont_vdf_ctrl #(
        .DAT_BITS(DW),
        .T_BITS(TW),
        .TIMEOUT_CYC(TMO),
        .MONT_RECIP_SQ(DW'(4))
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_dat(i_dat),
        .i_t(i_t),
        .i_val(i_val),
        .o_rdy(o_rdy),
        .o_dat(o_dat),
        .o_val(o_val),
        .i_rdy(i_rdy),
        .o_mul_a(o_mul_a),
        .o_mul_b(o_mul_b),
        .o_mul_val(o_mul_val),
        .i_mul_dat(i_mul_dat),
        .i_mul_val(i_mul_val),
        .o_iter(o_iter),
        .o_busy(o_busy),
        .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // core-model bookkeeping (written only by the core process)
    int launches   = 0;
    int viol       = 0;
    int stray_seen = 0;
    // core-model controls (written only by the main process)
    int stall_after = 0;
    int stray_req   = 0;
    int lat_mode    = 0;
    int lat_fix     = 3;

    function automatic longint unsigned ref_pow(input longint unsigned x,
                                                input int t);
        longint unsigned y;
        y = x % P;
        for (int i = 0; i < t; i++) y = (y * y) % P;
        return y;
    endfunction

    function automatic longint unsigned montmul(input longint unsigned a,
                                                input longint unsigned b);
        return (((a * b) % P) * RINV) % P;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Multiplier core model: answers each launch after 1..20 cycles,
    // and tallies any launch overlap or operand movement while busy.
    initial begin
        logic [63:0] a, b;
        int          lat;
        bit          abort;
        i_mul_val = 1'b0;
        i_mul_dat = '0;
        forever begin
            @(negedge clk);
            i_mul_val = 1'b0;
            if (stray_req != stray_seen) begin
                stray_seen++;
                i_mul_dat = DW'(12345);
                i_mul_val = 1'b1;
            end else if (o_mul_val && !i_rst) begin
                launches++;
                a = o_mul_a[63:0];
                b = o_mul_b[63:0];
                if (!(stall_after != 0 && launches >= stall_after)) begin
                    lat = lat_mode != 0 ? int'($urandom_range(1, 20)) : lat_fix;
                    abort = 1'b0;
                    for (int k = 0; k < lat; k++) begin
                        @(negedge clk);
                        if (i_rst) begin
                            abort = 1'b1;
                            break;
                        end
                        if (o_mul_val || o_mul_a[63:0] != a ||
                            o_mul_b[63:0] != b) viol++;
                    end
                    if (!abort) begin
                        i_mul_dat = DW'(montmul(a, b));
                        i_mul_val = 1'b1;
                    end
                end
            end
        end
    end

    task automatic start_job(input longint unsigned x, input int t);
        @(negedge clk);
        chk("rdy_at_req", 128'(o_rdy), 128'(1));
        i_dat = DW'(x);
        i_t   = TW'(t);
        i_val = 1'b1;
        @(negedge clk);
        i_val = 1'b0;
    endtask

    task automatic wait_val(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (o_val) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_job(input string tag, input longint unsigned x,
                           input int t, output int nl);
        int l0;
        bit ok;
        l0 = launches;
        start_job(x, t);
        chk({tag, "_busy"}, 128'(o_busy), 128'(1));
        wait_val(3000, ok);
        chk({tag, "_done"}, 128'(ok), 128'(1));
        chk({tag, "_dat"}, o_dat[127:0], 128'(ref_pow(x, t)));
        chk({tag, "_dat_hi"}, 128'(|o_dat[DW-1:128]), 128'(0));
        chk({tag, "_iter"}, 128'(o_iter), 128'(t));
        @(negedge clk);
        chk({tag, "_val_drop"}, 128'(o_val), 128'(0));
        chk({tag, "_busy_drop"}, 128'(o_busy), 128'(0));
        chk({tag, "_rdy_back"}, 128'(o_rdy), 128'(1));
        nl = launches - l0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nl;
        int  cyc;
        bit  ok;
        bit  saw_val;
        longint unsigned rx;
        int  rt;

        i_rst = 1'b1;
        i_val = 1'b0;
        i_rdy = 1'b1;
        i_dat = '0;
        i_t   = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 128'(o_rdy), 128'(1));
        chk("rst_val", 128'(o_val), 128'(0));
        chk("rst_mul_val", 128'(o_mul_val), 128'(0));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_err", 128'(o_err), 128'(0));
        chk("rst_dat", o_dat[127:0], 128'(0));
        chk("rst_mul_a", o_mul_a[127:0], 128'(0));
        chk("rst_mul_b", o_mul_b[127:0], 128'(0));
        chk("rst_iter", 128'(o_iter), 128'(0));

        // x=2, t=0
        run_job("t0", 2, 0, nl);
        chk("t0_launches", 128'(nl), 128'(2));

        // x=2, t=3 -> 256
        run_job("t3", 2, 3, nl);
        chk("t3_launches", 128'(nl), 128'(5));

        // x=3, t=2 fixed, then random latency, then random operands
        run_job("x3t2", 3, 2, nl);
        chk("x3t2_launches", 128'(nl), 128'(4));
        lat_mode = 1;
        for (int r = 0; r < 3; r++) begin
            run_job("x3t2_rl", 3, 2, nl);
        end
        for (int r = 0; r < 6; r++) begin
            rx = longint'($urandom_range(0, 32'(P - 1)));
            rt = int'($urandom_range(0, 6));
            run_job("rand", rx, rt, nl);
            chk("rand_launches", 128'(nl), 128'(rt + 2));
        end
        lat_mode = 0;

        // x=P-1, t=1 with consumer back-pressure
        i_rdy = 1'b0;
        start_job(P - 1, 1);
        wait_val(3000, ok);
        chk("bp_done", 128'(ok), 128'(1));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_val_hold", 128'(o_val), 128'(1));
            chk("bp_dat_hold", o_dat[127:0], 128'(ref_pow(P - 1, 1)));
            chk("bp_rdy_low", 128'(o_rdy), 128'(0));
        end
        i_rdy = 1'b1;
        @(negedge clk);
        chk("bp_val_drop", 128'(o_val), 128'(0));
        chk("bp_rdy_back", 128'(o_rdy), 128'(1));

        // core stall on the second launch -> timeout
        stall_after = launches + 2;
        start_job(3, 5);
        saw_val = 1'b0;
        ok = 1'b0;
        cyc = 0;
        for (int c = 0; c < TMO + 200; c++) begin
            if (o_err) begin
                ok = 1'b1;
                break;
            end
            if (o_val) saw_val = 1'b1;
            cyc++;
            @(negedge clk);
        end
        chk("tmo_err_set", 128'(ok), 128'(1));
        chk("tmo_not_early", 128'(cyc >= TMO), 128'(1));
        chk("tmo_no_val", 128'(saw_val), 128'(0));
        chk("tmo_busy", 128'(o_busy), 128'(0));
        chk("tmo_rdy", 128'(o_rdy), 128'(1));
        stall_after = 0;
        run_job("post_tmo", 5, 1, nl);
        chk("post_tmo_err", 128'(o_err), 128'(1));

        // reset in the middle of squaring
        lat_fix = 5;
        start_job(2, 5);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (o_iter == TW'(2)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_iter2", 128'(ok), 128'(1));
        #1 i_rst = 1'b1;
        #1;
        chk("arst_rdy", 128'(o_rdy), 128'(1));
        chk("arst_busy", 128'(o_busy), 128'(0));
        chk("arst_mul_val", 128'(o_mul_val), 128'(0));
        chk("arst_err", 128'(o_err), 128'(0));
        chk("arst_iter", 128'(o_iter), 128'(0));
        chk("arst_mul_a", o_mul_a[127:0], 128'(0));
        chk("arst_mul_b", o_mul_b[127:0], 128'(0));
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        stray_req++;
        repeat (4) @(negedge clk);
        chk("stray_sent", 128'(stray_seen), 128'(stray_req));
        chk("stray_rdy", 128'(o_rdy), 128'(1));
        chk("stray_busy", 128'(o_busy), 128'(0));
        chk("stray_val", 128'(o_val), 128'(0));
        chk("stray_dat", o_dat[127:0], 128'(0));
        chk("stray_mul_val", 128'(o_mul_val), 128'(0));
        lat_fix = 3;
        run_job("post_rst", 2, 1, nl);
        chk("post_rst_launches", 128'(nl), 128'(3));

        chk("one_outstanding", 128'(viol), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/redun_mont_vdf_ctrl.md
Name: redun_mont_vdf_ctrl

Overview:
Sequencer for one redundant Montgomery multiplier core (fe_t operands, modulus P, constants from redun_mont_pkg). It accepts a value x and an iteration count t, then computes x^(2^t) mod P. The sequence is: convert into Montgomery form, issue t back-to-back squarings, convert out, and present the result. It sits between the host/AXI-side loader and the multiplier core, and owns the core's operand muxing and operation counting.

Parameters:
DAT_BITS, 1040, field element width (matches package DAT_BITS)
T_BITS, 64, width of the iteration count t
TIMEOUT_CYC, 4096, max cycles from o_mul_val to i_mul_val before error

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_dat  in  DAT_BITS  input x (normal form, x < P)
i_t  in  T_BITS  number of squarings
i_val  in  1  request valid
o_rdy  out  1  request ready
o_dat  out  DAT_BITS  result x^(2^t) mod P (normal form)
o_val  out  1  result valid
i_rdy  in  1  result consumer ready
o_mul_a  out  DAT_BITS  multiplier operand a
o_mul_b  out  DAT_BITS  multiplier operand b
o_mul_val  out  1  one-cycle launch pulse to core
i_mul_dat  in  DAT_BITS  core result (Montgomery product, reduced < P)
i_mul_val  in  1  one-cycle core result strobe
o_iter  out  T_BITS  squarings completed in current job
o_busy  out  1  job in progress
o_err  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync release): state IDLE; o_rdy=1 after reset; o_val, o_mul_val, o_busy, o_err all 0; o_dat, o_mul_a, o_mul_b, o_iter all 0.
- Only one core operation is outstanding at any time. The core latency is variable; the controller only advances on i_mul_val.
- i_mul_val is ignored in IDLE, LAUNCH_* states and DONE (no state change, no data capture).
- State IDLE: o_rdy=1. On i_val&o_rdy: latch x and t, clear o_iter, set o_busy, go to TO_MONT.
- TO_MONT: launch with a=x, b=MONT_RECIP_SQ. On i_mul_val, register acc=i_mul_dat. If t==0 go to FROM_MONT, else go to SQUARE.
- SQUARE: launch with a=b=acc. On i_mul_val: acc=i_mul_dat and o_iter+=1. If o_iter+1==t go to FROM_MONT, else relaunch the next cycle.
- FROM_MONT: launch with a=acc, b=1. On i_mul_val: o_dat=i_mul_dat, o_val=1, go to DONE.
- DONE: hold o_dat and o_val until i_rdy. On o_val&i_rdy: o_val=0, o_busy=0, go to IDLE. o_rdy rises the cycle after the handshake.
- Launch timing: every launch is exactly one o_mul_val cycle, asserted the cycle after the state is entered or the previous result is captured. o_mul_a and o_mul_b are stable from launch until the matching i_mul_val.
- Minimum gap between results and the next launch is 1 cycle. Total job cycles = (t+2)×(core latency+1) + handshake overhead.
- Timeout: a counter starts at launch and clears on i_mul_val. If it reaches TIMEOUT_CYC: set o_err (sticky until i_rst), go to IDLE, drop o_busy, and do not assert o_val.
- o_iter compares at full T_BITS width, with no wrap. t=2^T_BITS-1 is legal and simply long.
- i_val while busy: o_rdy=0, the request is not accepted, and the request must be held by the source.
- Reset mid-job: immediate abort with all outputs at reset values. A late i_mul_val after reset is ignored.
- Input x ≥ P is out of contract; the result is then unspecified but the sequence still terminates.

Test Plan:
1. x=2, t=0 -> exactly 2 launches (to/from Montgomery); o_dat=2; o_iter=0.
2. x=2, t=3 -> 5 launches; o_dat=256; o_iter=3; o_busy falls after the handshake.
3. x=3, t=2 -> o_dat=81. Repeat with core latency randomised 1–20 cycles -> same result, one launch outstanding at a time.
4. x=P-1, t=1 -> o_dat=1. Hold i_rdy=0 for 10 cycles -> o_val and o_dat are stable, and o_rdy=0 throughout.
5. Core stalls after the 2nd launch of a t=5 job -> o_err=1 after TIMEOUT_CYC cycles, o_val stays 0, and IDLE is re-entered. The next job t=1, x=5 completes with 25 while o_err stays 1.
6. Assert i_rst during SQUARE with o_iter=2 -> all outputs return to reset values asynchronously. A stray i_mul_val after release is ignored, and a fresh job x=2, t=1 gives 4.
